// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and helpers for the write-back port arbiter.
// Register id 0 means "no destination" throughout the codebase.
package wb_port_arbiter_pkg;

    localparam int WB_NUM_FU_DEFAULT  = 4;
    localparam int WB_NUM_REG_DEFAULT = 8;
    localparam int WB_REG_BIT_DEFAULT = 16;
    localparam int WB_REG_ID_NONE     = 0;

    // Increment with wrap at n; n need not be a power of two.
    function automatic int wb_wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr wins.
// Rotates req so that ptr lands at bit 0, priority-finds, then rotates the index back.
module rr_pick #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gnt_id,
    output logic          any
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [PW-1:0]  offset;
    int             abs_id;

    always_comb begin
        doubled = {req, req};
        rotated = N'(doubled >> ptr);
        offset  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) offset = PW'(i);
        end
        abs_id = int'(offset) + int'(ptr);
        if (abs_id >= N) abs_id = abs_id - N;
        gnt_id = PW'(abs_id);
        any    = |req;
        grant  = any ? (N'(1) << gnt_id) : '0;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port among NUM_FU write-back requesters with
// round-robin grant and a single registered output slot.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_FU  = WB_NUM_FU_DEFAULT,
    parameter int NUM_REG = WB_NUM_REG_DEFAULT,
    parameter int REG_BIT = WB_REG_BIT_DEFAULT,
    localparam int REG_ID_BIT = $clog2(NUM_REG),
    localparam int FU_ID_BIT  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_FU-1:0]            fu2arb_write_vld,
    output logic [NUM_FU-1:0]            fu2arb_write_rdy,
    input  logic [NUM_FU*REG_ID_BIT-1:0] fu2arb_write_reg_id,
    input  logic [NUM_FU*REG_BIT-1:0]    fu2arb_write_data,
    output logic                         arb2sb_write_vld,
    input  logic                         arb2sb_write_rdy,
    output logic [REG_ID_BIT-1:0]        arb2sb_write_reg_id,
    output logic [REG_BIT-1:0]           arb2sb_write_data,
    output logic [FU_ID_BIT-1:0]         arb2sb_write_fu,
    output logic [NUM_REG-1:0]           arb_reg_inflight
);

    logic [REG_ID_BIT-1:0] req_id   [NUM_FU];
    logic [REG_BIT-1:0]    req_data [NUM_FU];
    logic [NUM_FU-1:0]     eligible;
    logic [NUM_FU-1:0]     drop;
    logic [NUM_FU-1:0]     pick_grant;
    logic [FU_ID_BIT-1:0]  pick_id;
    logic                  pick_any;
    logic                  slot_free;
    logic                  do_grant;

    logic                  out_vld_q;
    logic [REG_ID_BIT-1:0] out_id_q;
    logic [REG_BIT-1:0]    out_data_q;
    logic [FU_ID_BIT-1:0]  out_fu_q;
    logic [FU_ID_BIT-1:0]  ptr_q;

    // Id-0 writes have nowhere to go, so they are acked and dropped without using the slot.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            req_id[i]   = fu2arb_write_reg_id[i*REG_ID_BIT +: REG_ID_BIT];
            req_data[i] = fu2arb_write_data[i*REG_BIT +: REG_BIT];
            eligible[i] = fu2arb_write_vld[i] && (int'(req_id[i]) != WB_REG_ID_NONE);
            drop[i]     = fu2arb_write_vld[i] && (int'(req_id[i]) == WB_REG_ID_NONE);
        end
    end

    rr_pick #(.N(NUM_FU)) u_pick (
        .req    (eligible),
        .ptr    (ptr_q),
        .grant  (pick_grant),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    // Nothing is acked while reset is asserted, since the write would be lost.
    assign slot_free        = !out_vld_q || arb2sb_write_rdy;
    assign do_grant         = rst_n && slot_free && pick_any;
    assign fu2arb_write_rdy = (rst_n ? drop : '0) | (do_grant ? pick_grant : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_id_q   <= '0;
            out_data_q <= '0;
            out_fu_q   <= '0;
            ptr_q      <= '0;
        end else if (do_grant) begin
            out_vld_q  <= 1'b1;
            out_id_q   <= req_id[pick_id];
            out_data_q <= req_data[pick_id];
            out_fu_q   <= pick_id;
            ptr_q      <= FU_ID_BIT'(wb_wrap_inc(int'(pick_id), NUM_FU));
        end else if (out_vld_q && arb2sb_write_rdy) begin
            out_vld_q  <= 1'b0;
        end
    end

    assign arb2sb_write_vld    = out_vld_q;
    assign arb2sb_write_reg_id = out_id_q;
    assign arb2sb_write_data   = out_data_q;
    assign arb2sb_write_fu     = out_fu_q;

    // Lets the scoreboard keep the write-pending flag until the held write leaves.
    assign arb_reg_inflight = out_vld_q ? (NUM_REG'(1) << out_id_q) : '0;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scenario bench for wb_port_arbiter: directed checks plus a randomized run
// against a queue-based reference model of the round-robin write-back port.
module tb_wb_port_arbiter;

    localparam int NUM_FU     = 4;
    localparam int NUM_REG    = 8;
    localparam int REG_BIT    = 16;
    localparam int REG_ID_BIT = 3;
    localparam int FU_ID_BIT  = 2;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [NUM_FU-1:0]            fu_vld = '0;
    logic [NUM_FU-1:0]            fu_rdy;
    logic [NUM_FU*REG_ID_BIT-1:0] fu_id = '0;
    logic [NUM_FU*REG_BIT-1:0]    fu_data = '0;
    logic                         sb_vld;
    logic                         sb_rdy = 1'b0;
    logic [REG_ID_BIT-1:0]        sb_id;
    logic [REG_BIT-1:0]           sb_data;
    logic [FU_ID_BIT-1:0]         sb_fu;
    logic [NUM_REG-1:0]           inflight;

    wb_port_arbiter dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fu2arb_write_vld    (fu_vld),
        .fu2arb_write_rdy    (fu_rdy),
        .fu2arb_write_reg_id (fu_id),
        .fu2arb_write_data   (fu_data),
        .arb2sb_write_vld    (sb_vld),
        .arb2sb_write_rdy    (sb_rdy),
        .arb2sb_write_reg_id (sb_id),
        .arb2sb_write_data   (sb_data),
        .arb2sb_write_fu     (sb_fu),
        .arb_reg_inflight    (inflight)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int          in_id   [NUM_FU];
    logic [15:0] in_data [NUM_FU];

    // Reference model: one held slot plus the FU that has priority next.
    bit                m_vld;
    int                m_id;
    int                m_fu;
    int                m_ptr;
    logic [15:0]       m_data;
    logic [NUM_FU-1:0] exp_rdy;
    int                exp_g;
    logic              cur_rdy;

    logic [18:0] sb_q [NUM_FU][$];
    int          wait_cnt [NUM_FU];

    task automatic model_reset();
        m_vld = 0; m_id = 0; m_fu = 0; m_ptr = 0; m_data = '0;
        exp_g = -1; exp_rdy = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fu_vld = '0;
        sb_rdy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives one cycle of inputs and predicts which FUs should see rdy.
    task automatic apply(input logic [NUM_FU-1:0] v, input logic r);
        bit free;
        cur_rdy = r;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_id[i*REG_ID_BIT +: REG_ID_BIT] = 3'(in_id[i]);
            fu_data[i*REG_BIT +: REG_BIT]     = in_data[i];
        end
        fu_vld = v;
        sb_rdy = r;
        exp_rdy = '0;
        exp_g = -1;
        free = !m_vld || r;
        for (int i = 0; i < NUM_FU; i++)
            if (v[i] && in_id[i] == 0) exp_rdy[i] = 1'b1;
        if (free) begin
            for (int k = 0; k < NUM_FU; k++) begin
                int j;
                j = (m_ptr + k) % NUM_FU;
                if (exp_g < 0 && v[j] && in_id[j] != 0) exp_g = j;
            end
        end
        if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_g >= 0) begin
            m_vld = 1; m_id = in_id[exp_g]; m_data = in_data[exp_g];
            m_fu = exp_g; m_ptr = (exp_g + 1) % NUM_FU;
        end else if (m_vld && cur_rdy) begin
            m_vld = 0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (sb_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_vld: got %b expected 0", sb_vld); end
        total++; if (sb_id !== 3'd0 || sb_data !== 16'h0 || sb_fu !== 2'd0) begin
            bad++; $display("[TB] FAIL reset_outputs: got id=%0d data=%h fu=%0d expected all 0", sb_id, sb_data, sb_fu);
        end
        total++; if (inflight !== 8'h00) begin bad++; $display("[TB] FAIL reset_inflight: got %b expected 0", inflight); end
        total++; if (dut.ptr_q !== 2'd0) begin bad++; $display("[TB] FAIL reset_ptr: got %0d expected 0", dut.ptr_q); end
        total++; if (fu_rdy !== 4'b0000) begin bad++; $display("[TB] FAIL reset_rdy: got %b expected 0000", fu_rdy); end
    endtask

    task automatic test_single();
        in_id[2] = 5; in_data[2] = 16'hBEEF;
        apply(4'b0100, 1'b1);
        total++; if (fu_rdy !== 4'b0100) begin bad++; $display("[TB] FAIL single_rdy: got %b expected 0100", fu_rdy); end
        tick();
        total++; if (sb_vld !== 1'b1 || sb_id !== 3'd5 || sb_data !== 16'hBEEF || sb_fu !== 2'd2) begin
            bad++; $display("[TB] FAIL single_out: got vld=%b id=%0d data=%h fu=%0d expected 1/5/beef/2", sb_vld, sb_id, sb_data, sb_fu);
        end
        total++; if (inflight !== 8'b0010_0000) begin bad++; $display("[TB] FAIL single_inflight: got %b expected 00100000", inflight); end
        apply(4'b0000, 1'b1);
        tick();
        total++; if (sb_vld !== 1'b0) begin bad++; $display("[TB] FAIL single_drain: got vld=%b expected 0", sb_vld); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NUM_FU; i++) begin in_id[i] = i + 1; in_data[i] = 16'($urandom); end
        for (int k = 0; k < 8; k++) begin
            apply(4'b1111, 1'b1);
            total++; if (fu_rdy !== (4'b0001 << (k % 4))) begin
                bad++; $display("[TB] FAIL rr_rdy[%0d]: got %b expected %b", k, fu_rdy, 4'b0001 << (k % 4));
            end
            tick();
            total++; if (sb_vld !== 1'b1 || sb_fu !== 2'(k % 4) || sb_id !== 3'(k % 4 + 1)) begin
                bad++; $display("[TB] FAIL rr_out[%0d]: got vld=%b fu=%0d id=%0d expected 1/%0d/%0d", k, sb_vld, sb_fu, sb_id, k % 4, k % 4 + 1);
            end
        end
        apply(4'b0000, 1'b1);
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        in_id[0] = 1; in_id[1] = 2; in_id[3] = 4;
        for (int i = 0; i < NUM_FU; i++) in_data[i] = 16'($urandom);
        apply(4'b0001, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            apply(4'b1010, 1'b0);
            total++; if (fu_rdy !== 4'b0000) begin bad++; $display("[TB] FAIL stall_rdy[%0d]: got %b expected 0000", k, fu_rdy); end
            tick();
            total++; if (sb_vld !== 1'b1 || sb_fu !== 2'd0 || sb_id !== 3'd1 || sb_data !== in_data[0]) begin
                bad++; $display("[TB] FAIL stall_hold[%0d]: got vld=%b fu=%0d id=%0d data=%h expected 1/0/1/%h", k, sb_vld, sb_fu, sb_id, sb_data, in_data[0]);
            end
        end
        apply(4'b1010, 1'b1);
        total++; if (fu_rdy !== 4'b0010) begin bad++; $display("[TB] FAIL stall_release_rdy: got %b expected 0010", fu_rdy); end
        tick();
        total++; if (sb_vld !== 1'b1 || sb_fu !== 2'd1 || sb_id !== 3'd2 || sb_data !== in_data[1]) begin
            bad++; $display("[TB] FAIL stall_release_out: got fu=%0d id=%0d data=%h expected 1/2/%h", sb_fu, sb_id, sb_data, in_data[1]);
        end
        apply(4'b1000, 1'b1);
        total++; if (fu_rdy !== 4'b1000) begin bad++; $display("[TB] FAIL stall_fu3_rdy: got %b expected 1000", fu_rdy); end
        tick();
        apply(4'b0000, 1'b1);
        tick();
        total++; if (sb_vld !== 1'b0) begin bad++; $display("[TB] FAIL stall_drain: got vld=%b expected 0", sb_vld); end
    endtask

    task automatic test_id0_drop();
        do_reset();
        in_id[0] = 0; in_id[1] = 3;
        in_data[0] = 16'h1111; in_data[1] = 16'h3333;
        apply(4'b0011, 1'b1);
        total++; if (fu_rdy !== 4'b0011) begin bad++; $display("[TB] FAIL drop_rdy: got %b expected 0011", fu_rdy); end
        tick();
        total++; if (sb_vld !== 1'b1 || sb_id !== 3'd3 || sb_fu !== 2'd1 || sb_data !== 16'h3333) begin
            bad++; $display("[TB] FAIL drop_out: got vld=%b id=%0d fu=%0d data=%h expected 1/3/1/3333", sb_vld, sb_id, sb_fu, sb_data);
        end
        total++; if (dut.ptr_q !== 2'd2) begin bad++; $display("[TB] FAIL drop_ptr: got %0d expected 2", dut.ptr_q); end
        in_id[2] = 0;
        apply(4'b0101, 1'b0);
        total++; if (fu_rdy !== 4'b0101) begin bad++; $display("[TB] FAIL drop_stalled_rdy: got %b expected 0101", fu_rdy); end
        tick();
        apply(4'b0000, 1'b1);
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        in_id[0] = 2; in_data[0] = 16'hA5A5;
        apply(4'b0001, 1'b1);
        tick();
        apply(4'b0001, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        total++; if (sb_vld !== 1'b0 || inflight !== 8'h00) begin
            bad++; $display("[TB] FAIL async_rst_out: got vld=%b inflight=%b expected 0/0", sb_vld, inflight);
        end
        total++; if (dut.ptr_q !== 2'd0) begin bad++; $display("[TB] FAIL async_rst_ptr: got %0d expected 0", dut.ptr_q); end
        total++; if (fu_rdy !== 4'b0000) begin bad++; $display("[TB] FAIL async_rst_rdy: got %b expected 0000", fu_rdy); end
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_id[3] = 6; in_data[3] = 16'h0606;
        apply(4'b1000, 1'b1);
        total++; if (fu_rdy !== 4'b1000) begin bad++; $display("[TB] FAIL async_fu3_rdy: got %b expected 1000", fu_rdy); end
        tick();
        total++; if (sb_vld !== 1'b1 || sb_fu !== 2'd3 || sb_id !== 3'd6 || dut.ptr_q !== 2'd0) begin
            bad++; $display("[TB] FAIL async_fu3_out: got vld=%b fu=%0d id=%0d ptr=%0d expected 1/3/6/0", sb_vld, sb_fu, sb_id, dut.ptr_q);
        end
        apply(4'b0000, 1'b1);
        tick();
    endtask

    task automatic test_random();
        logic [NUM_FU-1:0] v;
        logic [NUM_FU-1:0] acc;
        logic              r;
        bit                xfer;
        int                xfu;
        logic [18:0]       xword;
        logic [18:0]       front;
        do_reset();
        v = '0;
        for (int i = 0; i < NUM_FU; i++) begin sb_q[i].delete(); wait_cnt[i] = 0; end
        for (int c = 0; c < 10000 + 3; c++) begin
            if (c < 10000) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (!v[i] && $urandom_range(1, 0) == 1) begin
                        v[i] = 1'b1;
                        in_id[i] = $urandom_range(7, 0);
                        in_data[i] = 16'($urandom);
                    end
                end
                r = ($urandom_range(9, 0) < 7);
            end else begin
                v = '0;
                r = 1'b1;
            end
            xfer = sb_vld && r;
            xfu = int'(sb_fu);
            xword = {sb_id, sb_data};
            apply(v, r);
            total++; if (fu_rdy !== exp_rdy) begin
                bad++; $display("[TB] FAIL rand_rdy[%0d]: got %b expected %b", c, fu_rdy, exp_rdy);
            end
            acc = fu_rdy & v;
            for (int i = 0; i < NUM_FU; i++)
                if (acc[i] && in_id[i] != 0) sb_q[i].push_back({3'(in_id[i]), in_data[i]});
            if (exp_g >= 0) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (i == exp_g) wait_cnt[i] = 0;
                    else if (v[i] && in_id[i] != 0) begin
                        wait_cnt[i]++;
                        total++; if (wait_cnt[i] >= NUM_FU) begin
                            bad++; $display("[TB] FAIL rand_starve[%0d]: fu%0d waited %0d grants, limit %0d", c, i, wait_cnt[i], NUM_FU - 1);
                        end
                    end
                end
            end
            tick();
            v = v & ~acc;
            if (xfer) begin
                total++; if (sb_q[xfu].size() == 0) begin
                    bad++; $display("[TB] FAIL rand_dup[%0d]: fu%0d write %h left with nothing pending", c, xfu, xword);
                end else begin
                    front = sb_q[xfu].pop_front();
                    if (xword !== front) begin
                        bad++; $display("[TB] FAIL rand_order[%0d]: fu%0d got %h expected %h", c, xfu, xword, front);
                    end
                end
            end
            total++; if (sb_vld !== m_vld || (m_vld && (sb_id !== 3'(m_id) || sb_data !== m_data || sb_fu !== 2'(m_fu)))) begin
                bad++; $display("[TB] FAIL rand_out[%0d]: got vld=%b id=%0d data=%h fu=%0d expected %b/%0d/%h/%0d",
                                c, sb_vld, sb_id, sb_data, sb_fu, m_vld, m_id, m_data, m_fu);
            end
            total++; if (inflight !== (m_vld ? (8'b1 << m_id) : 8'h00)) begin
                bad++; $display("[TB] FAIL rand_inflight[%0d]: got %b expected reg %0d vld %b", c, inflight, m_id, m_vld);
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            total++; if (sb_q[i].size() != 0) begin
                bad++; $display("[TB] FAIL rand_lost: fu%0d has %0d accepted writes never delivered, expected 0", i, sb_q[i].size());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_FU; i++) begin in_id[i] = 0; in_data[i] = '0; end
        model_reset();
        cur_rdy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_id0_drop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
